// File: rtl/snd_bus_sequencer.sv
// Write sequencer for the shared YM1/YM2/SAA1099 bus: buffers single-cycle host writes in a
// FIFO and replays each with fixed setup, strobe, hold and per-chip recovery timing.
module snd_bus_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_SETUP  = 2,
    parameter int unsigned WR_PULSE    = 4,
    parameter int unsigned YM_ADDR_REC = 24,
    parameter int unsigned YM_DATA_REC = 96,
    parameter int unsigned SAA_REC     = 8
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_target,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       overflow,
    output logic       busy,
    output logic       aa0,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       n_awr,
    output logic       n_ym1_cs,
    output logic       n_ym2_cs,
    output logic       n_saa_cs
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRecover} state_e;

    logic [10:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic [CntW-1:0] count_next;
    logic [10:0]     head;
    logic            req_take;
    logic            full;
    logic            push;
    logic            pop;

    state_e     state;
    logic [7:0] phase;
    logic [1:0] cur_target;

    // Phase counter holds (cycles - 1); a zero-length phase still occupies one cycle.
    function automatic logic [7:0] phase_load(input int unsigned n);
        if (n == 0) return 8'd0;
        return 8'(n - 1);
    endfunction

    // Recovery is chosen by the write that just finished, not by the next entry.
    function automatic logic [7:0] rec_load(input logic [1:0] tgt, input logic a0);
        if (tgt == 2'd2) return phase_load(SAA_REC);
        if (a0) return phase_load(YM_DATA_REC);
        return phase_load(YM_ADDR_REC);
    endfunction

    assign full      = (count == CntW'(FIFO_DEPTH));
    assign req_ready = ~full;
    assign head      = fifo_mem[rd_ptr];

    // Full is judged before any same-edge pop, so a pop never makes room for a push.
    always_comb begin
        req_take   = req_valid && (req_target != 2'd3);
        push       = req_take && !full;
        pop        = (count != '0) &&
                     ((state == StIdle) || ((state == StRecover) && (phase == 8'd0)));
        count_next = count + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk32) begin
        if (push) fifo_mem[wr_ptr] <= {req_target, req_a0, req_data};
    end

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            phase      <= 8'd0;
            cur_target <= 2'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            aa0        <= 1'b0;
            ad_out     <= 8'h00;
            ad_oe      <= 1'b0;
            n_awr      <= 1'b1;
            n_ym1_cs   <= 1'b1;
            n_ym2_cs   <= 1'b1;
            n_saa_cs   <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop) rd_ptr <= rd_ptr + PtrW'(1);
            count <= count_next;
            if (req_take && full) overflow <= 1'b1;

            case (state)
                StIdle: begin
                    busy <= (count_next != '0);
                end
                StSetup: begin
                    if (phase == 8'd0) begin
                        state <= StStrobe;
                        phase <= phase_load(WR_PULSE);
                        n_awr <= 1'b0;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                StStrobe: begin
                    if (phase == 8'd0) begin
                        state <= StHold;
                        n_awr <= 1'b1;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                StHold: begin
                    state    <= StRecover;
                    phase    <= rec_load(cur_target, aa0);
                    ad_oe    <= 1'b0;
                    n_ym1_cs <= 1'b1;
                    n_ym2_cs <= 1'b1;
                    n_saa_cs <= 1'b1;
                end
                StRecover: begin
                    if (phase == 8'd0) begin
                        state <= StIdle;
                        busy  <= (count_next != '0);
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase

            // A pop from IDLE or the end of RECOVER launches the next write directly.
            if (pop) begin
                state      <= StSetup;
                phase      <= phase_load(ADDR_SETUP);
                cur_target <= head[10:9];
                aa0        <= head[8];
                ad_out     <= head[7:0];
                ad_oe      <= 1'b1;
                n_ym1_cs   <= (head[10:9] != 2'd0);
                n_ym2_cs   <= (head[10:9] != 2'd1);
                n_saa_cs   <= (head[10:9] != 2'd2);
                busy       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snd_bus_sequencer.sv
// Bench for snd_bus_sequencer: directed requests push expected bus writes into a scoreboard;
// a bus monitor pops and checks each write plus its setup/strobe/window/period timing.
module tb_snd_bus_sequencer;

    logic       clk32 = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_target = 2'd0;
    logic       req_a0 = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       overflow;
    logic       busy;
    logic       aa0;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       n_awr;
    logic       n_ym1_cs;
    logic       n_ym2_cs;
    logic       n_saa_cs;

    snd_bus_sequencer dut (
        .clk32      (clk32),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_a0     (req_a0),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .overflow   (overflow),
        .busy       (busy),
        .aa0        (aa0),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .n_awr      (n_awr),
        .n_ym1_cs   (n_ym1_cs),
        .n_ym2_cs   (n_ym2_cs),
        .n_saa_cs   (n_saa_cs)
    );

    always #5 clk32 = ~clk32;

    typedef struct {
        logic [2:0] cs;
        logic       a0;
        logic [7:0] data;
        int         fall_at;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [2:0] mon_cs;
    logic [2:0] prev_cs = 3'b111;
    logic       prev_awr = 1'b1;
    int         cs_fall = 0;
    int         awr_fall = 0;
    int         last_fall = 0;

    localparam logic [2:0] CsYm1 = 3'b110;
    localparam logic [2:0] CsYm2 = 3'b101;
    localparam logic [2:0] CsSaa = 3'b011;

    always @(posedge clk32) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_wr(input logic [2:0] cs, input logic a0, input logic [7:0] data,
                             input int fall_at, input int gap);
        exp_t e;
        e.cs = cs; e.a0 = a0; e.data = data; e.fall_at = fall_at; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Called on a negedge; the request is sampled on the following posedge.
    task automatic drive(input logic [1:0] t, input logic a0, input logic [7:0] d);
        req_valid = 1'b1; req_target = t; req_a0 = a0; req_data = d;
        @(negedge clk32);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int exp_cyc, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk32);
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 0);
        chk("busy_fall_cycle", cyc, exp_cyc);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Bus monitor: checks every write against the scoreboard and its phase lengths.
    always @(negedge clk32) begin
        mon_cs = {n_saa_cs, n_ym2_cs, n_ym1_cs};
        if (rst) begin
            prev_cs  = 3'b111;
            prev_awr = 1'b1;
        end else begin
            if (mon_cs != 3'b111) chk("cs_onehot", $countones(~mon_cs), 1);
            chk("ad_oe_tracks_cs", 32'(ad_oe), 32'(mon_cs != 3'b111));
            if (prev_cs == 3'b111 && mon_cs != 3'b111) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(mon_cs), 32'h7);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_cs", 32'(mon_cs), 32'(mon_e.cs));
                    chk("wr_a0", 32'(aa0), 32'(mon_e.a0));
                    chk("wr_data", 32'(ad_out), 32'(mon_e.data));
                    if (mon_e.fall_at >= 0) chk("wr_latency", cyc, mon_e.fall_at);
                    if (mon_e.gap > 0) chk("wr_period", cyc - last_fall, mon_e.gap);
                end
                cs_fall   = cyc;
                last_fall = cyc;
            end
            if (prev_cs != 3'b111 && mon_cs == 3'b111) chk("cs_window", cyc - cs_fall, 7);
            if (prev_awr && !n_awr) begin
                chk("setup_len", cyc - cs_fall, 2);
                awr_fall = cyc;
            end
            if (!prev_awr && n_awr) chk("strobe_len", cyc - awr_fall, 4);
            prev_cs  = mon_cs;
            prev_awr = n_awr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;

        // Reset values
        repeat (3) @(negedge clk32);
        chk("rst_n_awr", 32'(n_awr), 1);
        chk("rst_cs", 32'({n_saa_cs, n_ym2_cs, n_ym1_cs}), 32'h7);
        chk("rst_ad_oe", 32'(ad_oe), 0);
        chk("rst_ad_out", 32'(ad_out), 0);
        chk("rst_aa0", 32'(aa0), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk32);

        // Single YM1 address write: CS low after E0+1, 24 recovery cycles
        c = cyc;
        expect_wr(CsYm1, 1'b0, 8'h07, c + 2, 0);
        drive(2'd0, 1'b0, 8'h07);
        wait_idle(c + 33, 200);

        // Burst of four YM2 data writes, 103 cycles apart
        repeat (3) @(negedge clk32);
        c = cyc;
        for (int i = 0; i < 4; i++)
            expect_wr(CsYm2, 1'b1, 8'(8'h11 + i), (i == 0) ? c + 2 : -1, (i == 0) ? 0 : 103);
        for (int i = 0; i < 4; i++) drive(2'd1, 1'b1, 8'(8'h11 + i));
        wait_idle(c + 414, 1000);

        // Overflow: six SAA requests, five accepted, the sixth dropped
        repeat (3) @(negedge clk32);
        c = cyc;
        for (int i = 0; i < 5; i++)
            expect_wr(CsSaa, 1'b0, 8'(8'h20 + i), (i == 0) ? c + 2 : -1, (i == 0) ? 0 : 15);
        for (int i = 0; i < 6; i++) drive(2'd2, 1'b0, 8'(8'h20 + i));
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_full_not_ready", 32'(req_ready), 0);
        wait_idle(c + 77, 300);
        chk("ovf_sticky", 32'(overflow), 1);

        // Mixed: YM1 data write then SAA; SAA recovery follows the YM1 data write
        repeat (3) @(negedge clk32);
        c = cyc;
        expect_wr(CsYm1, 1'b1, 8'h5A, c + 2, 0);
        expect_wr(CsSaa, 1'b1, 8'hC3, -1, 103);
        drive(2'd0, 1'b1, 8'h5A);
        drive(2'd2, 1'b1, 8'hC3);
        wait_idle(c + 120, 400);

        // Target 3 is ignored entirely
        repeat (3) @(negedge clk32);
        drive(2'd3, 1'b0, 8'hAA);
        for (int i = 0; i < 20; i++) begin
            chk("t3_busy", 32'(busy), 0);
            chk("t3_cs", 32'({n_saa_cs, n_ym2_cs, n_ym1_cs}), 32'h7);
            @(negedge clk32);
        end
        chk("t3_ready", 32'(req_ready), 1);

        // Reset during STROBE abandons the in-flight write and flushes the FIFO
        c = cyc;
        expect_wr(CsYm1, 1'b0, 8'h33, c + 2, 0);
        drive(2'd0, 1'b0, 8'h33);
        drive(2'd1, 1'b1, 8'h44);
        drive(2'd2, 1'b0, 8'h55);
        n = 0;
        while (n_awr !== 1'b0 && n < 10) begin
            @(negedge clk32);
            n++;
        end
        chk("strobe_reached", 32'(n_awr), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_n_awr", 32'(n_awr), 1);
        chk("async_rst_cs", 32'({n_saa_cs, n_ym2_cs, n_ym1_cs}), 32'h7);
        chk("async_rst_ad_oe", 32'(ad_oe), 0);
        repeat (2) @(negedge clk32);
        rst = 1'b0;
        chk("abandoned_write_consumed", exp_q.size(), 0);
        exp_q.delete();
        repeat (30) @(negedge clk32);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_overflow", 32'(overflow), 0);
        chk("post_rst_ready", 32'(req_ready), 1);
        chk("post_rst_cs", 32'({n_saa_cs, n_ym2_cs, n_ym1_cs}), 32'h7);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
